// File: rtl/orgate_operand_loader.sv
// Operand loader for the 3-bit OR gate datapath.
// Debounced button steps A/B capture from one switch bank.
module orgate_operand_loader #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic [1:0]       state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10,
    BAD    = 2'b11
  } state_t;

  logic             btn_m_q, btn_s_q;
  logic [WIDTH-1:0] sw_m_q, sw_s_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;
  state_t           state_q, state_d;
  logic             press;

  // Accept a new button level only after it holds for the full window
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (btn_s_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = btn_s_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign press = stable_q & ~stable_dly_q;

  // Capture sequence: A, then B, then a show phase that clears valid
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    state_d = state_q;
    unique case (state_q)
      LOAD_A: begin
        if (press) begin
          a_d     = sw_s_q;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (press) begin
          b_d     = sw_s_q;
          valid_d = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (press) begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = LOAD_A;
      end
    endcase
  end

  // All state, including synchronizers, clears on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      sw_m_q       <= '0;
      sw_s_q       <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      valid_q      <= 1'b0;
      state_q      <= LOAD_A;
    end else begin
      btn_m_q      <= btn;
      btn_s_q      <= btn_m_q;
      sw_m_q       <= sw;
      sw_s_q       <= sw_m_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      valid_q      <= valid_d;
      state_q      <= state_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = valid_q;
  assign state = state_q;

endmodule

// File: tb/tb_orgate_operand_loader.sv
// Directed bench for orgate_operand_loader.
// Debounce window shortened to 4 cycles.
module tb_orgate_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [2:0] sw;
  logic [2:0] a;
  logic [2:0] b;
  logic       valid;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  orgate_operand_loader #(
    .WIDTH(3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .sw   (sw),
    .a    (a),
    .b    (b),
    .valid(valid),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sw;
    logic [2:0] a;
    logic [2:0] b;
    logic       v;
    logic [1:0] st;
    logic [2:0] o;
  } vec_t;

  vec_t tbl[3];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm,
                         input logic [2:0] ea,
                         input logic [2:0] eb,
                         input logic ev,
                         input logic [1:0] es);
    chk({nm, ".a"}, 32'(a), 32'(ea));
    chk({nm, ".b"}, 32'(b), 32'(eb));
    chk({nm, ".valid"}, 32'(valid), 32'(ev));
    chk({nm, ".state"}, 32'(state), 32'(es));
  endtask

  initial begin
    tbl[0] = '{sw: 3'b010, a: 3'b111, b: 3'b010,
               v: 1'b1, st: 2'b10, o: 3'b111};
    tbl[1] = '{sw: 3'b110, a: 3'b111, b: 3'b010,
               v: 1'b0, st: 2'b00, o: 3'b111};
    tbl[2] = '{sw: 3'b110, a: 3'b110, b: 3'b010,
               v: 1'b0, st: 2'b01, o: 3'b110};

    rst = 1'b1;
    btn = 1'b1;
    sw  = 3'b111;
    step(3);
    chk_out("reset", 3'b000, 3'b000, 1'b0, 2'b00);
    chk("reset.cnt", 32'(dut.cnt_q), 32'd0);

    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk($sformatf("noload%0d.state", i),
          32'(state), 32'd0);
      chk($sformatf("noload%0d.a", i),
          32'(a), 32'd0);
    end
    step(1);
    chk_out("loadA", 3'b111, 3'b000, 1'b0, 2'b01);

    step(20);
    chk_out("holdA", 3'b111, 3'b000, 1'b0, 2'b01);

    btn = 1'b0;
    step(10);
    chk_out("relA", 3'b111, 3'b000, 1'b0, 2'b01);
    chk("relA.cnt", 32'(dut.cnt_q), 32'd0);

    btn = 1'b1;
    step(3);
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    step(8);
    chk_out("bounce", 3'b111, 3'b000, 1'b0, 2'b01);
    chk("bounce.cnt", 32'(dut.cnt_q), 32'd0);

    for (int i = 0; i < 3; i++) begin
      sw  = tbl[i].sw;
      btn = 1'b1;
      step(8);
      chk_out($sformatf("vec%0d", i), tbl[i].a,
              tbl[i].b, tbl[i].v, tbl[i].st);
      chk($sformatf("vec%0d.or", i),
          32'(a | b), 32'(tbl[i].o));
      btn = 1'b0;
      sw  = 3'b000;
      step(10);
      chk_out($sformatf("vec%0d_rel", i), tbl[i].a,
              tbl[i].b, tbl[i].v, tbl[i].st);
    end

    btn = 1'b1;
    step(3);
    chk("mid.cnt", 32'(dut.cnt_q), 32'd1);
    rst = 1'b1;
    step(1);
    chk_out("midrst", 3'b000, 3'b000, 1'b0, 2'b00);
    chk("midrst.cnt", 32'(dut.cnt_q), 32'd0);
    rst = 1'b0;
    btn = 1'b0;
    step(10);
    chk_out("postrst", 3'b000, 3'b000, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
